// File: rtl/data_sram_port.sv
`default_nettype none
// ============================================================================
// Module   : data_sram_port
// Brief    : req/gnt/rvalid slave port in front of a single-port synchronous
//            SRAM, one transaction in flight, optional wait states and
//            out-of-window error responses.
// Revision : 1.0 - initial release
// ============================================================================
module data_sram_port #(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          SIZE_BYTES  = 65536,
    parameter int          WAIT_STATES = 0,
    localparam int         AW          = $clog2(SIZE_BYTES / 4)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_i,
    output logic          gnt_o,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   addr_i,
    input  logic [31:0]   wdata_i,
    output logic          rvalid_o,
    output logic [31:0]   rdata_o,
    output logic          err_o,
    output logic          sram_cs_o,
    output logic          sram_we_o,
    output logic [3:0]    sram_be_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [31:0]   sram_wdata_o,
    input  logic [31:0]   sram_rdata_i
);

    localparam logic [1:0]  c_st_idle   = 2'd0;
    localparam logic [1:0]  c_st_wait   = 2'd1;
    localparam logic [1:0]  c_st_access = 2'd2;
    localparam logic [1:0]  c_st_resp   = 2'd3;
    localparam logic [2:0]  c_ws_load   = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
    localparam logic [31:0] c_size      = 32'(SIZE_BYTES);

    logic [1:0]    r_state;
    logic [2:0]    r_cnt;
    logic          r_we;
    logic [3:0]    r_be;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_rvalid;
    logic          r_err;
    logic          r_rd_resp;
    logic          r_sram_cs;
    logic          r_sram_we;
    logic [3:0]    r_sram_be;
    logic [AW-1:0] r_sram_addr;
    logic [31:0]   r_sram_wdata;

    logic [31:0]   w_off;
    logic          w_hit;
    logic          w_idle;
    logic          w_go_access;
    logic          w_nxt_we;
    logic [3:0]    w_nxt_be;
    logic [AW-1:0] w_nxt_addr;
    logic [31:0]   w_nxt_wdata;

    // Unsigned wrap makes addresses below the base land far outside the window.
    assign w_off  = addr_i - BASE_ADDR;
    assign w_hit  = w_off < c_size;
    assign w_idle = (r_state == c_st_idle);

    assign w_go_access = (w_idle && req_i && w_hit && (WAIT_STATES == 0)) ||
                         ((r_state == c_st_wait) && (r_cnt == 3'd0));

    // Zero-wait accesses launch straight from the request inputs.
    assign w_nxt_we    = w_idle ? we_i    : r_we;
    assign w_nxt_be    = w_idle ? be_i    : r_be;
    assign w_nxt_addr  = w_idle ? w_off[AW+1:2] : r_addr;
    assign w_nxt_wdata = w_idle ? wdata_i : r_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_st_idle;
            r_cnt        <= 3'd0;
            r_we         <= 1'b0;
            r_be         <= 4'd0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_rvalid     <= 1'b0;
            r_err        <= 1'b0;
            r_rd_resp    <= 1'b0;
            r_sram_cs    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_be    <= 4'd0;
            r_sram_addr  <= '0;
            r_sram_wdata <= 32'd0;
        end else begin
            r_rvalid     <= 1'b0;
            r_err        <= 1'b0;
            r_rd_resp    <= 1'b0;
            r_sram_cs    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_be    <= 4'd0;
            r_sram_addr  <= '0;
            r_sram_wdata <= 32'd0;

            case (r_state)
                c_st_idle: begin
                    if (req_i) begin
                        r_we    <= we_i;
                        r_be    <= be_i;
                        r_addr  <= w_off[AW+1:2];
                        r_wdata <= wdata_i;
                        if (!w_hit) begin
                            r_state  <= c_st_resp;
                            r_rvalid <= 1'b1;
                            r_err    <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            r_state <= c_st_wait;
                            r_cnt   <= c_ws_load;
                        end else begin
                            r_state <= c_st_access;
                        end
                    end
                end
                c_st_wait: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= c_st_access;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                c_st_access: begin
                    r_state   <= c_st_resp;
                    r_rvalid  <= 1'b1;
                    r_rd_resp <= !r_we;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase

            if (w_go_access) begin
                // An all-lanes-off write completes without touching the macro.
                r_sram_cs    <= !(w_nxt_we && (w_nxt_be == 4'd0));
                r_sram_we    <= w_nxt_we;
                r_sram_be    <= w_nxt_be;
                r_sram_addr  <= w_nxt_addr;
                r_sram_wdata <= w_nxt_wdata;
            end
        end
    end

    assign gnt_o        = w_idle && rst;
    assign rvalid_o     = r_rvalid;
    assign err_o        = r_err;
    assign rdata_o      = r_rd_resp ? sram_rdata_i : 32'd0;
    assign sram_cs_o    = r_sram_cs;
    assign sram_we_o    = r_sram_we;
    assign sram_be_o    = r_sram_be;
    assign sram_addr_o  = r_sram_addr;
    assign sram_wdata_o = r_sram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_sram_port
// Brief    : Scoreboard bench for data_sram_port, one instance with zero and
//            one with three wait states, each backed by a behavioural SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_sram_port;

    localparam logic [31:0] c_base = 32'h0001_0000;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic        clk;
    logic        rst;
    logic        req        [2];
    logic        gnt        [2];
    logic        we         [2];
    logic [3:0]  be         [2];
    logic [31:0] addr       [2];
    logic [31:0] wdata      [2];
    logic        rvalid     [2];
    logic [31:0] rdata      [2];
    logic        err        [2];
    logic        sram_cs    [2];
    logic        sram_we    [2];
    logic [3:0]  sram_be    [2];
    logic [13:0] sram_addr  [2];
    logic [31:0] sram_wdata [2];
    logic [31:0] sram_rdata [2];

    resp_t exp_q [2][$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    last_acc  [2];
    logic  last_hold [2];
    logic  last_err  [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [31:0] mem [0:16383];

        data_sram_port #(
            .BASE_ADDR   (c_base),
            .SIZE_BYTES  (65536),
            .WAIT_STATES ((k == 0) ? 0 : 3)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .req_i        (req[k]),
            .gnt_o        (gnt[k]),
            .we_i         (we[k]),
            .be_i         (be[k]),
            .addr_i       (addr[k]),
            .wdata_i      (wdata[k]),
            .rvalid_o     (rvalid[k]),
            .rdata_o      (rdata[k]),
            .err_o        (err[k]),
            .sram_cs_o    (sram_cs[k]),
            .sram_we_o    (sram_we[k]),
            .sram_be_o    (sram_be[k]),
            .sram_addr_o  (sram_addr[k]),
            .sram_wdata_o (sram_wdata[k]),
            .sram_rdata_i (sram_rdata[k])
        );

        always @(posedge clk) begin
            if (sram_cs[k]) begin
                if (sram_we[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sram_be[k][b]) mem[sram_addr[k]][8*b +: 8] <= sram_wdata[k][8*b +: 8];
                    end
                end else begin
                    sram_rdata[k] <= mem[sram_addr[k]];
                end
            end
        end

        // Response monitor: every strobe must match the oldest outstanding expectation.
        always @(negedge clk) begin
            if (rvalid[k]) begin
                if (exp_q[k].size() == 0) begin
                    chk($sformatf("dut%0d_unexpected_rvalid", k), 32'd1, 32'd0);
                end else begin
                    resp_t e;
                    e = exp_q[k].pop_front();
                    chk($sformatf("dut%0d_rdata", k), rdata[k], e.rdata);
                    chk($sformatf("dut%0d_err", k), {31'd0, err[k]}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic xact(input int k, input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                        input logic exp_cs, input logic hold);
        int    ws, acc, cs_first, rv_first, cs_n, waited;
        logic  gnt_bad;
        resp_t e;
        ws = (k == 0) ? 0 : 3;
        @(negedge clk);
        req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
        waited = 0;
        while (!gnt[k] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!gnt[k]) begin
            chk($sformatf("dut%0d_gnt_timeout", k), 32'd0, 32'd1);
            req[k] = 1'b0;
            return;
        end
        acc = cyc;
        if (last_hold[k]) begin
            chk($sformatf("dut%0d_accept_gap", k), acc - last_acc[k], last_err[k] ? 2 : 3 + ws);
        end
        last_acc[k] = acc; last_hold[k] = hold; last_err[k] = exp_err;
        e.rdata = exp_rd; e.err = exp_err;
        exp_q[k].push_back(e);
        cs_first = -1; rv_first = -1; cs_n = 0; gnt_bad = 1'b0;
        for (int i = 0; i < 20 && rv_first < 0; i++) begin
            @(negedge clk);
            if (i == 0 && !hold) req[k] = 1'b0;
            if (sram_cs[k]) begin
                cs_n++;
                if (cs_first < 0) begin
                    cs_first = cyc - acc;
                    chk($sformatf("dut%0d_sram_addr", k), {18'd0, sram_addr[k]}, (a - c_base) >> 2);
                    chk($sformatf("dut%0d_sram_we", k), {31'd0, sram_we[k]}, {31'd0, w});
                    if (w) chk($sformatf("dut%0d_sram_wdata", k), sram_wdata[k], d);
                end
            end
            if (gnt[k]) gnt_bad = 1'b1;
            if (rvalid[k]) rv_first = cyc - acc;
        end
        chk($sformatf("dut%0d_gnt_busy", k), {31'd0, gnt_bad}, 32'd0);
        chk($sformatf("dut%0d_cs_count", k), cs_n, exp_cs ? 1 : 0);
        if (exp_cs) chk($sformatf("dut%0d_cs_latency", k), cs_first, 1 + ws);
        chk($sformatf("dut%0d_rvalid_latency", k), rv_first, exp_err ? 1 : 2 + ws);
        if (!hold) req[k] = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; be[k] = 4'd0; addr[k] = 32'd0; wdata[k] = 32'd0;
            last_acc[k] = 0; last_hold[k] = 1'b0; last_err[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("dut%0d_reset_gnt", k), {31'd0, gnt[k]}, 32'd0);
            chk($sformatf("dut%0d_reset_rvalid", k), {31'd0, rvalid[k]}, 32'd0);
            chk($sformatf("dut%0d_reset_cs", k), {31'd0, sram_cs[k]}, 32'd0);
            chk($sformatf("dut%0d_reset_rdata", k), rdata[k], 32'd0);
        end
        rst = 1'b1;

        // Zero wait states: full word, byte lane, window edges, empty write, held request.
        xact(0, 1'b1, 4'hF, 32'h0001_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 1'b0);
        xact(0, 1'b0, 4'hF, 32'h0001_0010, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        xact(0, 1'b1, 4'hF, 32'h0001_0020, 32'h1122_3344, 32'h0, 1'b0, 1'b1, 1'b0);
        xact(0, 1'b1, 4'h4, 32'h0001_0020, 32'h00AB_0000, 32'h0, 1'b0, 1'b1, 1'b0);
        xact(0, 1'b0, 4'hF, 32'h0001_0020, 32'h0,        32'h11AB_3344, 1'b0, 1'b1, 1'b0);
        xact(0, 1'b0, 4'hF, 32'h0002_0000, 32'h0,        32'h0, 1'b1, 1'b0, 1'b1);
        xact(0, 1'b0, 4'hF, 32'h0000_FFFC, 32'h0,        32'h0, 1'b1, 1'b0, 1'b1);
        xact(0, 1'b1, 4'h0, 32'h0001_0020, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1);
        xact(0, 1'b0, 4'hF, 32'h0001_0020, 32'h0,        32'h11AB_3344, 1'b0, 1'b1, 1'b1);
        xact(0, 1'b1, 4'hF, 32'h0001_FFFC, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, 1'b1);
        xact(0, 1'b0, 4'h0, 32'h0001_FFFC, 32'h0,        32'hCAFE_F00D, 1'b0, 1'b1, 1'b0);

        // Three wait states.
        xact(1, 1'b1, 4'hF, 32'h0001_0040, 32'h1234_5678, 32'h0, 1'b0, 1'b1, 1'b1);
        xact(1, 1'b0, 4'hF, 32'h0001_0040, 32'h0,        32'h1234_5678, 1'b0, 1'b1, 1'b1);
        xact(1, 1'b0, 4'hF, 32'h0002_0000, 32'h0,        32'h0, 1'b1, 1'b0, 1'b1);
        xact(1, 1'b1, 4'h3, 32'h0001_0040, 32'h0000_AAAA, 32'h0, 1'b0, 1'b1, 1'b0);
        xact(1, 1'b0, 4'hF, 32'h0001_0040, 32'h0,        32'h1234_AAAA, 1'b0, 1'b1, 1'b0);

        // Reset while the SRAM access is on the bus: abandoned, no response.
        last_hold[1] = 1'b0;
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h0001_0040;
        for (int i = 0; i < 10 && !gnt[1]; i++) @(negedge clk);
        @(negedge clk);
        req[1] = 1'b0;
        for (int i = 0; i < 10 && !sram_cs[1]; i++) @(negedge clk);
        chk("dut1_cs_before_reset", {31'd0, sram_cs[1]}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("dut1_cs_async_drop", {31'd0, sram_cs[1]}, 32'd0);
        chk("dut1_gnt_in_reset", {31'd0, gnt[1]}, 32'd0);
        repeat (2) @(negedge clk);
        chk("dut1_rvalid_in_reset", {31'd0, rvalid[1]}, 32'd0);
        rst = 1'b1;
        xact(1, 1'b0, 4'hF, 32'h0001_0040, 32'h0, 32'h1234_AAAA, 1'b0, 1'b1, 1'b0);

        repeat (5) @(negedge clk);
        chk("dut0_queue_drained", exp_q[0].size(), 32'd0);
        chk("dut1_queue_drained", exp_q[1].size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
